msg_write: RTL

MSG_WRITE -- requirements
Module: msg_write

---
 rtl/msg_write.sv | 116 +++++++++++
 1 files changed

// File: rtl/msg_write.sv
// Builds a 10-byte reply frame (header, address, read data, inverted header) from one OPB read
// and streams it into the UART TX FIFO. A read that never gets RDACK yields an error frame.
module msg_write #(
    parameter logic [7:0]  RSP_HEADER  = 8'h5C,
    parameter logic [7:0]  ERR_HEADER  = 8'h5E,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        OPB_RE,
    input  logic [31:0] OPB_ADDR,
    input  logic        OPB_RDACK,
    input  logic [31:0] OPB_DI,
    output logic        TX_FIFO_WR,
    output logic [7:0]  TX_FIFO_DATA,
    input  logic        TX_FIFO_FULL,
    output logic        BUSY,
    output logic        error_flag
);

    typedef enum logic [2:0] {IDLE, WAIT_ACK, SEND, DONE, ERROR} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [7:0]  hdr_q;
    logic [3:0]  byte_cnt;
    logic [15:0] wait_cnt;
    logic [7:0]  frame_byte;
    logic        send;

    always_comb begin
        frame_byte = 8'h00;
        case (byte_cnt)
            4'd0:    frame_byte = hdr_q;
            4'd1:    frame_byte = addr_q[31:24];
            4'd2:    frame_byte = addr_q[23:16];
            4'd3:    frame_byte = addr_q[15:8];
            4'd4:    frame_byte = addr_q[7:0];
            4'd5:    frame_byte = data_q[31:24];
            4'd6:    frame_byte = data_q[23:16];
            4'd7:    frame_byte = data_q[15:8];
            4'd8:    frame_byte = data_q[7:0];
            4'd9:    frame_byte = ~hdr_q;
            default: frame_byte = 8'h00;
        endcase
    end

    assign send         = (state == SEND);
    assign TX_FIFO_WR   = send && !TX_FIFO_FULL;
    assign TX_FIFO_DATA = send ? frame_byte : 8'h00;
    assign BUSY         = (state != IDLE);

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state      <= IDLE;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            hdr_q      <= 8'h00;
            byte_cnt   <= 4'd0;
            wait_cnt   <= 16'd0;
            error_flag <= 1'b0;
        end else begin
            // A read strobe arriving while a frame is in flight is dropped and flagged.
            error_flag <= (state != IDLE) && OPB_RE;
            case (state)
                IDLE: begin
                    if (OPB_RE) begin
                        addr_q   <= OPB_ADDR;
                        wait_cnt <= 16'd0;
                        if (OPB_RDACK) begin
                            data_q <= OPB_DI;
                            hdr_q  <= RSP_HEADER;
                            state  <= SEND;
                        end else begin
                            state <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // RDACK wins over a timeout landing in the same cycle.
                    if (OPB_RDACK) begin
                        data_q <= OPB_DI;
                        hdr_q  <= RSP_HEADER;
                        state  <= SEND;
                    end else if (wait_cnt + 16'd1 >= ACK_TIMEOUT) begin
                        data_q     <= 32'h0;
                        hdr_q      <= ERR_HEADER;
                        error_flag <= 1'b1;
                        state      <= ERROR;
                    end
                end
                SEND: begin
                    if (TX_FIFO_WR) begin
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'd9) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    byte_cnt <= 4'd0;
                    state    <= IDLE;
                end
                ERROR: begin
                    state <= SEND;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
